// File: rtl/radix_alu_q_if.sv
// Command/result bus of radix_alu_q: tagged command handshake in, tagged result handshake out,
// plus occupancy/status. The bench drives the master side, the ALU is the slave.
`timescale 1ns/1ps
interface radix_alu_q_if #(
  parameter int W     = 16,
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic [3:0]               in_opcode;
  logic [W-1:0]             in_a;
  logic [W-1:0]             in_b;
  logic [TAG_W-1:0]         in_tag;
  logic                     out_valid;
  logic                     out_ready;
  logic [2*W-1:0]           out_result;
  logic [TAG_W-1:0]         out_tag;
  logic                     out_err;
  logic                     busy;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport master (
    output in_valid, in_opcode, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_err, busy, fifo_count
  );

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_err, busy, fifo_count
  );
endinterface

// File: rtl/radix_alu_q.sv
// Queued radix ALU: DEPTH-entry command FIFO feeding a single IDLE/EXEC/HOLD engine whose
// execute time depends on the opcode class (binary, decimal, duodecimal core models).
`timescale 1ns/1ps
module radix_alu_q #(
  parameter int W       = 16,
  parameter int TAG_W   = 4,
  parameter int DEPTH   = 4,
  parameter int LAT_BIN = 6,
  parameter int LAT_DEC = 8,
  parameter int LAT_DUO = 1
) (
  input logic         clk,
  input logic         rst,
  radix_alu_q_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Opcode table shared with the sequencer; 11..15 are illegal.
  localparam logic [3:0] OP_BIN_ADD   = 4'd0;
  localparam logic [3:0] OP_BIN_SUB   = 4'd1;
  localparam logic [3:0] OP_BIN_MUL   = 4'd2;
  localparam logic [3:0] OP_DEC_ADD   = 4'd3;
  localparam logic [3:0] OP_DEC_SUB   = 4'd4;
  localparam logic [3:0] OP_DEC_MUL   = 4'd5;
  localparam logic [3:0] OP_DEC_MUL10 = 4'd6;
  localparam logic [3:0] OP_DUO_ADD12 = 4'd7;
  localparam logic [3:0] OP_DUO_SUB12 = 4'd8;
  localparam logic [3:0] OP_DUO_MUL12 = 4'd9;
  localparam logic [3:0] OP_DUO_MUL3  = 4'd10;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  function automatic logic [31:0] sat_lat(input int lat);
    return (lat < 1) ? 32'd1 : 32'(lat);
  endfunction

  function automatic logic [31:0] class_lat(input logic [3:0] op);
    if (op <= OP_BIN_MUL)        return sat_lat(LAT_BIN);
    else if (op <= OP_DEC_MUL10) return sat_lat(LAT_DEC);
    else if (op <= OP_DUO_MUL3)  return sat_lat(LAT_DUO);
    else                         return 32'd1;
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_DUO_MUL3;
  endfunction

  function automatic logic [2*W-1:0] compute(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [2*W-1:0] ax;
    logic [2*W-1:0] bx;
    ax = {{W{1'b0}}, a};
    bx = {{W{1'b0}}, b};
    case (op)
      OP_BIN_ADD, OP_DEC_ADD, OP_DUO_ADD12: return ax + bx;
      OP_BIN_SUB, OP_DEC_SUB, OP_DUO_SUB12: return ax - bx;
      OP_BIN_MUL, OP_DEC_MUL, OP_DUO_MUL12: return ax * bx;
      OP_DEC_MUL10:                         return ax * (2*W)'(10);
      OP_DUO_MUL3:                          return ax * (2*W)'(3);
      default:                              return '0;
    endcase
  endfunction

  logic [3:0]       op_mem  [DEPTH];
  logic [W-1:0]     a_mem   [DEPTH];
  logic [W-1:0]     b_mem   [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [1:0]       state;
  logic [31:0]      cnt_p0;
  logic [3:0]       op_p0;
  logic [W-1:0]     a_p0, b_p0;
  logic [TAG_W-1:0] tag_p0;
  logic             vld_p1;
  logic [2*W-1:0]   result_p1;
  logic [TAG_W-1:0] tag_p1;
  logic             err_p1;
  logic             push, pop, nempty;

  // in_ready depends only on the registered count, so a same-cycle pop never frees a full FIFO.
  assign nempty = (count != '0);
  assign push   = bus.in_valid && (count != FULL);
  assign pop    = nempty && ((state == IDLE) || ((state == HOLD) && bus.out_ready));

  assign bus.in_ready   = (count != FULL);
  assign bus.fifo_count = count;
  assign bus.busy       = nempty || (state != IDLE);
  assign bus.out_valid  = vld_p1;
  assign bus.out_result = result_p1;
  assign bus.out_tag    = tag_p1;
  assign bus.out_err    = err_p1;

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]  <= bus.in_opcode;
      a_mem[wr_ptr]   <= bus.in_a;
      b_mem[wr_ptr]   <= bus.in_b;
      tag_mem[wr_ptr] <= bus.in_tag;
    end
  end

  // Stage p0: command popped from the FIFO head into the execute registers.
  always_ff @(posedge clk) begin
    if (pop) begin
      op_p0  <= op_mem[rd_ptr];
      a_p0   <= a_mem[rd_ptr];
      b_p0   <= b_mem[rd_ptr];
      tag_p0 <= tag_mem[rd_ptr];
    end
  end

  // Stage p1: result register held until the consumer accepts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      state     <= IDLE;
      cnt_p0    <= '0;
      vld_p1    <= 1'b0;
      result_p1 <= '0;
      tag_p1    <= '0;
      err_p1    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      case (state)
        IDLE: begin
          if (pop) begin
            cnt_p0 <= class_lat(op_mem[rd_ptr]);
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_p0 > 32'd1) begin
            cnt_p0 <= cnt_p0 - 32'd1;
          end else begin
            vld_p1    <= 1'b1;
            result_p1 <= compute(op_p0, a_p0, b_p0);
            tag_p1    <= tag_p0;
            err_p1    <= !is_legal(op_p0);
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            vld_p1 <= 1'b0;
            if (pop) begin
              cnt_p0 <= class_lat(op_mem[rd_ptr]);
              state  <= EXEC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_radix_alu_q.sv
// Bench for radix_alu_q: directed latency/boundary steps plus a randomized stream with
// random backpressure, every result checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_radix_alu_q;
  localparam int W = 16, TAG_W = 4, DEPTH = 4, LAT_BIN = 6, LAT_DEC = 8, LAT_DUO = 1;

  localparam logic [3:0] OP_BIN_ADD = 4'd0, OP_BIN_SUB = 4'd1, OP_BIN_MUL = 4'd2;
  localparam logic [3:0] OP_DEC_ADD = 4'd3, OP_DEC_SUB = 4'd4, OP_DEC_MUL = 4'd5;
  localparam logic [3:0] OP_DEC_MUL10 = 4'd6, OP_DUO_ADD12 = 4'd7, OP_DUO_SUB12 = 4'd8;
  localparam logic [3:0] OP_DUO_MUL12 = 4'd9, OP_DUO_MUL3 = 4'd10;

  typedef struct {
    logic [2*W-1:0]   res;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  radix_alu_q_if #(.W(W), .TAG_W(TAG_W), .DEPTH(DEPTH)) bus ();

  radix_alu_q #(
    .W(W), .TAG_W(TAG_W), .DEPTH(DEPTH),
    .LAT_BIN(LAT_BIN), .LAT_DEC(LAT_DEC), .LAT_DUO(LAT_DUO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t model_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 0;
  bit   rand_bp  = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on wide integers, reduced modulo 2^(2W).
  function automatic exp_t predict(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [TAG_W-1:0] tag);
    exp_t e;
    longint unsigned la, lb, r;
    la = 64'(a);
    lb = 64'(b);
    e.tag = tag;
    e.err = 1'b0;
    if (op inside {OP_BIN_ADD, OP_DEC_ADD, OP_DUO_ADD12})      r = la + lb;
    else if (op inside {OP_BIN_SUB, OP_DEC_SUB, OP_DUO_SUB12}) r = la - lb;
    else if (op inside {OP_BIN_MUL, OP_DEC_MUL, OP_DUO_MUL12}) r = la * lb;
    else if (op == OP_DEC_MUL10)                               r = la * 10;
    else if (op == OP_DUO_MUL3)                                r = la * 3;
    else begin
      r = 0;
      e.err = 1'b1;
    end
    r = r % (64'd1 << (2*W));
    e.res = r[2*W-1:0];
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic try_push(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TAG_W-1:0] tag, input int max_wait, output bit ok);
    ok = 0;
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_tag    = tag;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        model_q.push_back(predict(op, a, b, tag));
        tick();
        break;
      end
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TAG_W-1:0] tag);
    bit ok;
    try_push(op, a, b, tag, 60, ok);
    check("push_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_out(input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (bus.out_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    check({name, "_busy"}, 64'(bus.busy), 64'd0);
    check({name, "_queue_empty"}, 64'(model_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: every handshake must match the model head; held results must not move.
  logic [2*W-1:0]   hold_res;
  logic [TAG_W-1:0] hold_tag;
  logic             hold_err;
  bit               holding = 0;
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (holding && bus.out_valid) begin
        check("hold_result", 64'(bus.out_result), 64'(hold_res));
        check("hold_tag", 64'(bus.out_tag), 64'(hold_tag));
        check("hold_err", 64'(bus.out_err), 64'(hold_err));
      end
      holding = 0;
      if (bus.out_valid && bus.out_ready) begin
        if (model_q.size() == 0) begin
          check("out_valid_unexpected", 64'(bus.out_valid), 64'd0);
        end else begin
          exp_t e;
          e = model_q.pop_front();
          check("result", 64'(bus.out_result), 64'(e.res));
          check("tag", 64'(bus.out_tag), 64'(e.tag));
          check("err", 64'(bus.out_err), 64'(e.err));
        end
      end else if (bus.out_valid) begin
        holding  = 1;
        hold_res = bus.out_result;
        hold_tag = bus.out_tag;
        hold_err = bus.out_err;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int acc;
    bit ok;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_opcode = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_result", 64'(bus.out_result), 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    check("rst_out_err", 64'(bus.out_err), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_fifo_count", 64'(bus.fifo_count), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    mon_en = 1;
    @(posedge clk);
    #1;

    // DUO fast path
    send(OP_DUO_MUL3, 16'd100, 16'd0, 4'd3);
    wait_out(30, cyc);
    check("duo_latency", 64'(cyc), 64'd2);
    check("duo_result", 64'(bus.out_result), 64'd300);
    check("duo_tag", 64'(bus.out_tag), 64'd3);
    check("duo_err", 64'(bus.out_err), 64'd0);
    tick();

    // BIN subtract wraps
    send(OP_BIN_SUB, 16'd5, 16'd7, 4'd1);
    wait_out(30, cyc);
    check("sub_latency", 64'(cyc), 64'd7);
    check("sub_result", 64'(bus.out_result), 64'hFFFF_FFFE);
    tick();

    // Largest product
    send(OP_BIN_MUL, 16'hFFFF, 16'hFFFF, 4'd2);
    wait_out(30, cyc);
    check("mul_latency", 64'(cyc), 64'd7);
    check("mul_result", 64'(bus.out_result), 64'hFFFE_0001);
    tick();

    // DEC scaling
    send(OP_DEC_MUL10, 16'd1234, 16'd0, 4'd5);
    wait_out(30, cyc);
    check("mul10_latency", 64'(cyc), 64'd9);
    check("mul10_result", 64'(bus.out_result), 64'd12340);
    tick();

    // Backpressure: engine holds one, FIFO holds DEPTH
    bus.out_ready = 1'b0;
    acc = 0;
    for (int t = 0; t < 8; t++) begin
      try_push(OP_DUO_ADD12, 16'(t), 16'd1, 4'(t), 3, ok);
      acc += int'(ok);
    end
    @(negedge clk);
    check("bp_accepted", 64'(acc), 64'd5);
    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    check("bp_fifo_count", 64'(bus.fifo_count), 64'd4);
    check("bp_out_tag", 64'(bus.out_tag), 64'd0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    tick();
    @(negedge clk);
    check("bp_in_ready_reopen", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    for (int t = 5; t < 8; t++) send(OP_DUO_ADD12, 16'(t), 16'd1, 4'(t));
    drain("bp_drain");

    // Illegal opcode
    send(4'hF, 16'd77, 16'd88, 4'd9);
    wait_out(30, cyc);
    check("illegal_latency", 64'(cyc), 64'd2);
    check("illegal_err", 64'(bus.out_err), 64'd1);
    check("illegal_result", 64'(bus.out_result), 64'd0);
    tick();

    // Reset in the middle of EXEC discards the command
    send(OP_DEC_ADD, 16'd1, 16'd2, 4'd4);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_q.delete();
    @(negedge clk);
    check("midrst_fifo_count", 64'(bus.fifo_count), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    for (int i = 0; i < 12; i++) begin
      check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    send(OP_DUO_ADD12, 16'd2, 16'd3, 4'd6);
    wait_out(30, cyc);
    check("post_rst_latency", 64'(cyc), 64'd2);
    check("post_rst_result", 64'(bus.out_result), 64'd5);
    tick();

    // Randomized stream with random backpressure
    rand_bp = 1;
    for (int n = 0; n < 80; n++) begin
      send(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 4'($urandom));
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 12)) tick();
    end
    rand_bp = 0;
    bus.out_ready = 1'b1;
    drain("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
